// File: rtl/sc_game_sequencer.sv
// sc_game_sequencer: game-flow controller for the Frogger datapath.
// Owns the lives and level counters, sequences the playfield through
// start / play / death / level-up / game-over / win phases by driving the
// active-low clear and run-enable strobes, and exposes its state encoding
// for debug and display.
//
// Inputs from the lower state machines (Losing, Winning) are plain level
// indications with no handshake: they are only looked at while in PLAY,
// and any other time they are ignored.
module sc_game_sequencer #(
  parameter int LIVES_INIT   = 3,
  parameter int LEVELS_MAX   = 4,
  parameter int PAUSE_CYCLES = 50000000
) (
  input  logic       SC_GAMESEQ_CLOCK_50,
  input  logic       SC_GAMESEQ_RESET_InHigh,
  input  logic       SC_GAMESEQ_startButton_InLow,
  input  logic       SC_GAMESEQ_Losing_InLow,
  input  logic       SC_GAMESEQ_Winning_InLow,
  output logic       SC_GAMESEQ_clear_OutLow,
  output logic       SC_GAMESEQ_run_OutLow,
  output logic [2:0] SC_GAMESEQ_lives_Out,
  output logic [2:0] SC_GAMESEQ_level_Out,
  output logic       SC_GAMESEQ_gameOver_Out,
  output logic       SC_GAMESEQ_gameWin_Out,
  output logic [2:0] SC_GAMESEQ_state_Out
);

  localparam int CNT_W = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
  localparam logic [2:0] LEVEL_LAST = 3'(LEVELS_MAX);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_IDLE       = 3'd1,
    ST_LOAD_LEVEL = 3'd2,
    ST_PLAY       = 3'd3,
    ST_DEATH      = 3'd4,
    ST_LEVEL_UP   = 3'd5,
    ST_GAME_OVER  = 3'd6,
    ST_WIN        = 3'd7
  } state_t;

  state_t           state;
  logic [2:0]       lives;
  logic [2:0]       level;
  logic [CNT_W-1:0] pause_cnt;
  logic             start_q;
  logic             start_press;

  // A press is a 1 -> 0 transition of the debounced button. start_q resets
  // to 1, but RESET never looks at the press, so a button held low through
  // reset has already been sampled low by the time IDLE looks at it.
  assign start_press = start_q & ~SC_GAMESEQ_startButton_InLow;

  // Game-flow state machine with the lives, level and pause counters.
  always_ff @(posedge SC_GAMESEQ_CLOCK_50 or posedge SC_GAMESEQ_RESET_InHigh) begin
    if (SC_GAMESEQ_RESET_InHigh) begin
      state     <= ST_RESET;
      lives     <= LIVES_LOAD;
      level     <= 3'd1;
      pause_cnt <= '0;
      start_q   <= 1'b1;
    end else begin
      start_q   <= SC_GAMESEQ_startButton_InLow;
      // The pause counter idles at zero; only the pause states count it up.
      pause_cnt <= '0;
      case (state)
        ST_RESET: begin
          state <= ST_IDLE;
        end
        ST_IDLE, ST_GAME_OVER, ST_WIN: begin
          if (start_press) begin
            lives <= LIVES_LOAD;
            level <= 3'd1;
            state <= ST_LOAD_LEVEL;
          end
        end
        ST_LOAD_LEVEL: begin
          state <= ST_PLAY;
        end
        ST_PLAY: begin
          // Losing takes priority over winning in the same cycle.
          if (!SC_GAMESEQ_Losing_InLow) begin
            if (lives != 3'd0) lives <= lives - 3'd1;
            state <= ST_DEATH;
          end else if (!SC_GAMESEQ_Winning_InLow) begin
            if (level < LEVEL_LAST) begin
              level <= level + 3'd1;
              state <= ST_LEVEL_UP;
            end else begin
              state <= ST_WIN;
            end
          end
        end
        ST_DEATH: begin
          if (pause_cnt == PAUSE_LAST) begin
            state <= (lives == 3'd0) ? ST_GAME_OVER : ST_LOAD_LEVEL;
          end else begin
            pause_cnt <= pause_cnt + 1'b1;
          end
        end
        ST_LEVEL_UP: begin
          if (pause_cnt == PAUSE_LAST) begin
            state <= ST_LOAD_LEVEL;
          end else begin
            pause_cnt <= pause_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

  // Moore output decode from the state and counter registers.
  always_comb begin
    SC_GAMESEQ_clear_OutLow = !((state == ST_RESET) || (state == ST_LOAD_LEVEL));
    SC_GAMESEQ_run_OutLow   = (state != ST_PLAY);
    SC_GAMESEQ_gameOver_Out = (state == ST_GAME_OVER);
    SC_GAMESEQ_gameWin_Out  = (state == ST_WIN);
    SC_GAMESEQ_lives_Out    = lives;
    SC_GAMESEQ_level_Out    = level;
    SC_GAMESEQ_state_Out    = state;
  end

endmodule

// File: tb/tb_sc_game_sequencer.sv
// Directed bench for sc_game_sequencer with PAUSE_CYCLES=4, LIVES_INIT=3,
// LEVELS_MAX=2. Inputs change 1 ns after the rising edge and outputs are
// checked at that same point, so every observation sees settled values.
module tb_sc_game_sequencer;

  localparam int P_PAUSE  = 4;
  localparam int P_LIVES  = 3;
  localparam int P_LEVELS = 2;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic       losing;
  logic       winning;
  logic       clear_n;
  logic       run_n;
  logic [2:0] lives;
  logic [2:0] level;
  logic       game_over;
  logic       game_win;
  logic [2:0] state;

  int checks;
  int failures;

  sc_game_sequencer #(
    .LIVES_INIT  (P_LIVES),
    .LEVELS_MAX  (P_LEVELS),
    .PAUSE_CYCLES(P_PAUSE)
  ) dut (
    .SC_GAMESEQ_CLOCK_50         (clk),
    .SC_GAMESEQ_RESET_InHigh     (rst),
    .SC_GAMESEQ_startButton_InLow(start_btn),
    .SC_GAMESEQ_Losing_InLow     (losing),
    .SC_GAMESEQ_Winning_InLow    (winning),
    .SC_GAMESEQ_clear_OutLow     (clear_n),
    .SC_GAMESEQ_run_OutLow       (run_n),
    .SC_GAMESEQ_lives_Out        (lives),
    .SC_GAMESEQ_level_Out        (level),
    .SC_GAMESEQ_gameOver_Out     (game_over),
    .SC_GAMESEQ_gameWin_Out      (game_win),
    .SC_GAMESEQ_state_Out        (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks a pause of exact length, then the single LOAD_LEVEL cycle, ending in PLAY.
  task automatic run_pause(input logic [2:0] exp_state, input logic [2:0] exp_after);
    for (int i = 0; i < P_PAUSE; i++) begin
      checks++;
      if (state !== exp_state || run_n !== 1'b1) begin
        failures++;
        $display("FAIL pause_cycle%0d state=%0d run=%0b expected state=%0d run=1", i, state, run_n, exp_state);
      end
      tick();
    end
    checks++;
    if (state !== exp_after) begin
      failures++;
      $display("FAIL pause_exit state=%0d expected %0d", state, exp_after);
    end
    if (exp_after == 3'd2) begin
      checks++;
      if (clear_n !== 1'b0) begin
        failures++;
        $display("FAIL pause_load_clear clear=%0b expected 0", clear_n);
      end
      tick();
      checks++;
      if (state !== 3'd3 || run_n !== 1'b0 || clear_n !== 1'b1) begin
        failures++;
        $display("FAIL pause_replay state=%0d run=%0b clear=%0b expected 3/0/1", state, run_n, clear_n);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_btn = 1'b1; losing = 1'b1; winning = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || clear_n !== 1'b0 || run_n !== 1'b1 || lives !== 3'd3 ||
        level !== 3'd1 || game_over !== 1'b0 || game_win !== 1'b0) begin
      failures++;
      $display("FAIL reset_values st=%0d clr=%0b run=%0b lives=%0d lvl=%0d go=%0b win=%0b expected 0/0/1/3/1/0/0",
               state, clear_n, run_n, lives, level, game_over, game_win);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (state !== 3'd1 || clear_n !== 1'b1 || run_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_to_idle st=%0d clr=%0b run=%0b expected 1/1/1", state, clear_n, run_n);
    end
    // Losing while idle must be ignored.
    losing = 1'b0;
    tick();
    losing = 1'b1;
    checks++;
    if (state !== 3'd1 || lives !== 3'd3) begin
      failures++;
      $display("FAIL idle_ignore_losing st=%0d lives=%0d expected 1/3", state, lives);
    end
  endtask

  task automatic test_start();
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    checks++;
    if (state !== 3'd2 || clear_n !== 1'b0 || run_n !== 1'b1 || lives !== 3'd3 || level !== 3'd1) begin
      failures++;
      $display("FAIL start_load st=%0d clr=%0b run=%0b lives=%0d lvl=%0d expected 2/0/1/3/1",
               state, clear_n, run_n, lives, level);
    end
    tick();
    checks++;
    if (state !== 3'd3 || clear_n !== 1'b1 || run_n !== 1'b0) begin
      failures++;
      $display("FAIL start_play st=%0d clr=%0b run=%0b expected 3/1/0", state, clear_n, run_n);
    end
    tick();
    checks++;
    if (state !== 3'd3 || run_n !== 1'b0) begin
      failures++;
      $display("FAIL play_holds st=%0d run=%0b expected 3/0", state, run_n);
    end
  endtask

  task automatic test_death();
    losing = 1'b0;
    tick();
    losing = 1'b1;
    checks++;
    if (state !== 3'd4 || lives !== 3'd2 || run_n !== 1'b1) begin
      failures++;
      $display("FAIL death_entry st=%0d lives=%0d run=%0b expected 4/2/1", state, lives, run_n);
    end
    run_pause(3'd4, 3'd2);
  endtask

  task automatic test_game_over();
    logic [2:0] exp_lives;
    exp_lives = 3'd1;
    for (int d = 0; d < 2; d++) begin
      losing = 1'b0;
      tick();
      losing = 1'b1;
      checks++;
      if (lives !== exp_lives) begin
        failures++;
        $display("FAIL gameover_lives got=%0d expected %0d", lives, exp_lives);
      end
      if (exp_lives == 3'd0) run_pause(3'd4, 3'd6);
      else run_pause(3'd4, 3'd2);
      exp_lives = exp_lives - 3'd1;
    end
    checks++;
    if (state !== 3'd6 || game_over !== 1'b1 || run_n !== 1'b1 || clear_n !== 1'b1) begin
      failures++;
      $display("FAIL gameover_state st=%0d go=%0b run=%0b clr=%0b expected 6/1/1/1", state, game_over, run_n, clear_n);
    end
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    checks++;
    if (state !== 3'd2 || clear_n !== 1'b0 || lives !== 3'd3 || level !== 3'd1 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL gameover_restart st=%0d clr=%0b lives=%0d lvl=%0d go=%0b expected 2/0/3/1/0",
               state, clear_n, lives, level, game_over);
    end
    tick();
  endtask

  task automatic test_level_win();
    winning = 1'b0;
    tick();
    winning = 1'b1;
    checks++;
    if (state !== 3'd5 || level !== 3'd2 || lives !== 3'd3) begin
      failures++;
      $display("FAIL levelup_entry st=%0d lvl=%0d lives=%0d expected 5/2/3", state, level, lives);
    end
    run_pause(3'd5, 3'd2);
    winning = 1'b0;
    tick();
    winning = 1'b1;
    checks++;
    if (state !== 3'd7 || game_win !== 1'b1 || level !== 3'd2 || run_n !== 1'b1) begin
      failures++;
      $display("FAIL win_entry st=%0d win=%0b lvl=%0d run=%0b expected 7/1/2/1", state, game_win, level, run_n);
    end
    tick();
    checks++;
    if (state !== 3'd7 || game_win !== 1'b1) begin
      failures++;
      $display("FAIL win_holds st=%0d win=%0b expected 7/1", state, game_win);
    end
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    checks++;
    if (state !== 3'd2 || level !== 3'd1 || lives !== 3'd3 || game_win !== 1'b0) begin
      failures++;
      $display("FAIL win_restart st=%0d lvl=%0d lives=%0d win=%0b expected 2/1/3/0", state, level, lives, game_win);
    end
    tick();
  endtask

  task automatic test_both_and_reset();
    losing = 1'b0; winning = 1'b0;
    tick();
    losing = 1'b1; winning = 1'b1;
    checks++;
    if (state !== 3'd4 || lives !== 3'd2 || level !== 3'd1) begin
      failures++;
      $display("FAIL both_priority st=%0d lives=%0d lvl=%0d expected 4/2/1", state, lives, level);
    end
    tick();
    // Second pause cycle: assert reset asynchronously with the button held low.
    start_btn = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || clear_n !== 1'b0 || run_n !== 1'b1 || lives !== 3'd3 ||
        level !== 3'd1 || game_over !== 1'b0 || game_win !== 1'b0) begin
      failures++;
      $display("FAIL async_reset st=%0d clr=%0b run=%0b lives=%0d lvl=%0d expected 0/0/1/3/1",
               state, clear_n, run_n, lives, level);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL held_button_idle st=%0d expected 1", state);
    end
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    checks++;
    if (state !== 3'd2 || clear_n !== 1'b0) begin
      failures++;
      $display("FAIL repress_load st=%0d clr=%0b expected 2/0", state, clear_n);
    end
    // Losing during the clear cycle must be ignored.
    losing = 1'b0;
    tick();
    losing = 1'b1;
    checks++;
    if (state !== 3'd3 || lives !== 3'd3) begin
      failures++;
      $display("FAIL load_ignore_losing st=%0d lives=%0d expected 3/3", state, lives);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_start();
    test_death();
    test_game_over();
    test_level_win();
    test_both_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_game_sequencer.md
# sc_game_sequencer

Game-flow controller for the Frogger datapath. It owns the lives and level counters and sequences the playfield registers through start, play, death, level-up, game-over and win phases by driving their clear and run-enable strobes. It sits above the background, frog and point state machines and consumes their losing and last-register (goal reached) indications.

## Interface

Parameters:
- LIVES_INIT, 3: lives loaded at game start; legal range 1..7.
- LEVELS_MAX, 4: number of levels; clearing level LEVELS_MAX wins the game; legal range 1..7.
- PAUSE_CYCLES, 50000000: freeze length after a death or level-up (1 s at 50 MHz); must be ≥1.

Ports:
- SC_GAMESEQ_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_GAMESEQ_RESET_InHigh  in  1  reset; asynchronous, active-high.
- SC_GAMESEQ_startButton_InLow  in  1  start button, active low, already debounced.
- SC_GAMESEQ_Losing_InLow  in  1  frog died, active low; sampled only in PLAY.
- SC_GAMESEQ_Winning_InLow  in  1  frog reached last register, active low; sampled only in PLAY.
- SC_GAMESEQ_clear_OutLow  out  1  datapath clear, active low.
- SC_GAMESEQ_run_OutLow  out  1  datapath run enable, active low; high freezes the playfield.
- SC_GAMESEQ_lives_Out  out  3  remaining lives.
- SC_GAMESEQ_level_Out  out  3  current level, 1-based.
- SC_GAMESEQ_gameOver_Out  out  1  high in GAME_OVER.
- SC_GAMESEQ_gameWin_Out  out  1  high in WIN.
- SC_GAMESEQ_state_Out  out  3  current state encoding, for debug and display.

## Operation

- States and encodings: RESET=0, IDLE=1, LOAD_LEVEL=2, PLAY=3, DEATH=4, LEVEL_UP=5, GAME_OVER=6, WIN=7. State register is Moore; all outputs decode from state and counter registers only.
- Start edge: a registered copy of startButton (reset value 1) detects a press when the previous sample is 1 and the current sample is 0. A button held low through reset produces no press until it is released and pressed again.
- RESET: clear=0, run=1. Goes unconditionally to IDLE on the next clock.
- IDLE: clear=1, run=1. On a start press, load lives=LIVES_INIT and level=1, then go to LOAD_LEVEL.
- LOAD_LEVEL: clear=0 for exactly one cycle, run=1, then go to PLAY.
- PLAY: clear=1, run=0.
  - If Losing=0: decrement lives (saturates at 0) and go to DEATH.
  - Otherwise, if Winning=0 and level<LEVELS_MAX: increment level and go to LEVEL_UP.
  - Otherwise, if Winning=0 and level==LEVELS_MAX: go to WIN; level is unchanged.
  - When Losing and Winning are both 0 in the same cycle, losing wins.
- DEATH and LEVEL_UP: clear=1, run=1. The pause counter is zeroed on entry and counts one per cycle. On the cycle the counter equals PAUSE_CYCLES-1:
  - DEATH goes to GAME_OVER if lives==0, else to LOAD_LEVEL.
  - LEVEL_UP goes to LOAD_LEVEL.
- GAME_OVER (gameOver=1) and WIN (gameWin=1): clear=1, run=1. On a start press, reload lives=LIVES_INIT and level=1, then go to LOAD_LEVEL.
- Pause counter width is $clog2(PAUSE_CYCLES+1). It holds 0 outside DEATH and LEVEL_UP.
- Any undefined state value returns to RESET on the next clock.

## Timing

- Reset values of all outputs: clear_OutLow=0, run_OutLow=1, lives_Out=LIVES_INIT, level_Out=1, gameOver_Out=0, gameWin_Out=0, state_Out=0.
- Asserting reset mid-operation forces RESET immediately and asynchronously, including during a pause; counters reload and the start-edge register returns to 1.
- Start press to clear pulse: IDLE sees the press in cycle N, LOAD_LEVEL (clear=0) occupies cycle N+1, PLAY (run=0) begins in cycle N+2.
- Losing or winning sampled in PLAY in cycle N: the new state and updated counter appear in cycle N+1, so run rises in N+1.
- A pause spans exactly PAUSE_CYCLES cycles in DEATH or LEVEL_UP, then one LOAD_LEVEL cycle, then PLAY.
- Losing and Winning are ignored outside PLAY, including while clear is asserted.

## Test plan

All scenarios use PAUSE_CYCLES=4, LIVES_INIT=3 and LEVELS_MAX=2.

- Reset, then a start press → state 1→2→3. clear_OutLow=0 for exactly one cycle; lives=3, level=1; run_OutLow=0 from the PLAY cycle onward.
- In PLAY, Losing=0 for one cycle → DEATH with lives=2 and run=1 for 4 cycles, then one LOAD_LEVEL cycle, then PLAY.
- Three deaths → lives 2, 1, 0. After the third pause, state=6 and gameOver_Out=1. A start press then gives lives=3, level=1 and a LOAD_LEVEL pulse.
- Winning=0 at level 1 → LEVEL_UP with level=2 and a 4-cycle pause. Winning=0 at level 2 → WIN in the next cycle; gameWin_Out=1, level stays 2.
- Losing=0 and Winning=0 in the same PLAY cycle → DEATH; level unchanged, lives decremented.
- Reset asserted on pause cycle 2 → state=0 immediately with all reset values. Start held low through reset release → stays in IDLE until the button is released and pressed again.
